alu_uart_ctrl: RTL and testbench

Byte-serial sequencer for the combinational ALU. It sits between the UART receiver/transmitter and the ALU. It collects three bytes from the receiver in order (operand A, operand B, opcode), validates the opcode, and presents the registered operands to the ALU. It then captures the result and hands it to the transmitter with a start/done handshake. Incomplete frames are discarded by a gap timeout.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_uart_ctrl_gap_timer.sv | 41 ++++
 rtl/alu_uart_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_uart_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer state encoding and
// the opcode legality check used when the opcode byte arrives.
package alu_pkg;

  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD = 6'b100000;
  localparam logic [OPW-1:0] OP_SUB = 6'b100010;
  localparam logic [OPW-1:0] OP_AND = 6'b100100;
  localparam logic [OPW-1:0] OP_OR  = 6'b100101;
  localparam logic [OPW-1:0] OP_XOR = 6'b100110;
  localparam logic [OPW-1:0] OP_SRA = 6'b000011;
  localparam logic [OPW-1:0] OP_SRL = 6'b000010;
  localparam logic [OPW-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  function automatic logic is_valid_op(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_ctrl_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and raises a
// single-cycle expire when the count would reach TIMEOUT_CYCLES.
// A TIMEOUT_CYCLES of 0 never expires. Clear wins over expiry so a byte
// arriving on the expiry cycle suppresses the timeout.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = (TIMEOUT_CYCLES > 0) && enable_i && !clear_i && (cnt_q == LAST);

  // Next count: clear or expiry restarts, otherwise count while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Byte-serial ALU sequencer: collects operand A, operand B and opcode from
// the UART receiver, drives registered operands to the external ALU, then
// hands the ALU result to the transmitter with a start/done handshake.
module alu_uart_ctrl
  import alu_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int N_OPS          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Rx_Done,
  input  logic [N_BITS-1:0] Rx_Data,
  input  logic              Tx_Done,
  output logic              Tx_Start,
  output logic [N_BITS-1:0] Tx_Data,
  output logic [N_BITS-1:0] Alu_A,
  output logic [N_BITS-1:0] Alu_B,
  output logic [N_OPS-1:0]  Alu_Op,
  input  logic [N_BITS-1:0] Alu_Result,
  output logic              Busy,
  output logic              Err_Op,
  output logic              Err_Timeout
);

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   a_q, a_d;
  logic [N_BITS-1:0]   b_q, b_d;
  logic [N_OPS-1:0]    op_q, op_d;
  logic [N_BITS-1:0]   txd_q, txd_d;
  logic                txs_q, txs_d;
  logic                eop_q, eop_d;
  logic                eto_q, eto_d;

  logic                gap_clear;
  logic                gap_enable;
  logic                gap_expire;
  logic                op_byte_ok;

  // The opcode byte is legal only with its upper bits clear and a known code
  assign op_byte_ok = ((Rx_Data >> N_OPS) == '0) && is_valid_op(Rx_Data[N_OPS-1:0]);

  // Gap timing only runs between bytes of a partially received frame
  assign gap_enable = (state_q == WAIT_B) || (state_q == WAIT_OP);
  assign gap_clear  = Rx_Done || !gap_enable;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (gap_clear),
    .enable_i (gap_enable),
    .expire_o (gap_expire)
  );

  // Next-state and datapath decode; pulses default low every cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    txd_d   = txd_q;
    txs_d   = 1'b0;
    eop_d   = 1'b0;
    eto_d   = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (Rx_Done) begin
          a_d     = Rx_Data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (Rx_Done) begin
          b_d     = Rx_Data;
          state_d = WAIT_OP;
        end else if (gap_expire) begin
          eto_d   = 1'b1;
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (Rx_Done) begin
          if (op_byte_ok) begin
            op_d    = Rx_Data[N_OPS-1:0];
            state_d = EXEC;
          end else begin
            eop_d   = 1'b1;
            state_d = WAIT_A;
          end
        end else if (gap_expire) begin
          eto_d   = 1'b1;
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        txd_d   = Alu_Result;
        txs_d   = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        // A done that coincides with our own start belongs to an older byte
        if (Tx_Done && !txs_q) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  // State, operand and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      eop_q   <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      eop_q   <= eop_d;
      eto_q   <= eto_d;
    end
  end

  assign Alu_A       = a_q;
  assign Alu_B       = b_q;
  assign Alu_Op      = op_q;
  assign Tx_Data     = txd_q;
  assign Tx_Start    = txs_q;
  assign Err_Op      = eop_q;
  assign Err_Timeout = eto_q;
  assign Busy        = (state_q == EXEC) || (state_q == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl with a behavioural ALU beside it and
// a frame-level reference model of the expected results and error pulses.
`timescale 1ns/1ps
module tb_alu_uart_ctrl;

  localparam int NB = 8;
  localparam int NO = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_done;
  logic [NB-1:0] rx_data;
  logic          tx_done;
  logic          tx_start;
  logic [NB-1:0] tx_data;
  logic [NB-1:0] alu_a;
  logic [NB-1:0] alu_b;
  logic [NO-1:0] alu_op;
  logic [NB-1:0] alu_result;
  logic          busy;
  logic          err_op;
  logic          err_to;

  int n_checks = 0;
  int n_errors = 0;
  int n_txs    = 0;
  int n_eto    = 0;

  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [5:0] m_op;

  logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

  always #5 clk = ~clk;

  alu_uart_ctrl #(
    .N_BITS(NB), .N_OPS(NO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Rx_Done     (rx_done),
    .Rx_Data     (rx_data),
    .Tx_Done     (tx_done),
    .Tx_Start    (tx_start),
    .Tx_Data     (tx_data),
    .Alu_A       (alu_a),
    .Alu_B       (alu_b),
    .Alu_Op      (alu_op),
    .Alu_Result  (alu_result),
    .Busy        (busy),
    .Err_Op      (err_op),
    .Err_Timeout (err_to)
  );

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit op_ok(input logic [7:0] op);
    for (int i = 0; i < 8; i++) begin
      if (valid_ops[i] == op) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Combinational ALU sitting beside the sequencer
  always_comb alu_result = ref_alu(alu_a, alu_b, alu_op);

  // Pulse counters used for "nothing happened" checks
  always @(negedge clk) begin
    if (tx_start) n_txs <= n_txs + 1;
    if (err_to)   n_eto <= n_eto + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 5)) @(posedge clk);
  endtask

  task automatic pulse_tx();
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    gap();
    send_byte(b);
    gap();
    send_byte(op);
    m_a = a;
    m_b = b;
  endtask

  task automatic expect_result(input logic [7:0] exp_res, input bit busy_rx);
    int k;
    @(negedge clk);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_no_start", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("tx_start", 32'(tx_start), 32'd1);
    check("tx_data", 32'(tx_data), 32'(exp_res));
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
    check("alu_op", 32'(alu_op), 32'(m_op));
    k = $urandom_range(0, 3);
    repeat (k) begin
      @(negedge clk);
      check("wait_tx_busy", 32'(busy), 32'd1);
      check("start_single", 32'(tx_start), 32'd0);
    end
    if (busy_rx) send_byte(8'hAA);
    pulse_tx();
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("tx_data_hold", 32'(tx_data), 32'(exp_res));
  endtask

  task automatic expect_reject();
    int s;
    s = n_txs;
    @(negedge clk);
    check("err_op", 32'(err_op), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_keep_op", 32'(alu_op), 32'(m_op));
    check("err_alu_a", 32'(alu_a), 32'(m_a));
    @(negedge clk);
    check("err_op_single", 32'(err_op), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("no_start_after_err", 32'(n_txs), 32'(s));
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit busy_rx);
    send_frame(a, b, op);
    if (op_ok(op)) begin
      m_op = op[5:0];
      expect_result(ref_alu(a, b, op[5:0]), busy_rx);
    end else begin
      expect_reject();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = '0;
    tx_done = 1'b0;
    m_a = '0; m_b = '0; m_op = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_op", 32'(err_op), 32'd0);
    check("rst_err_to", 32'(err_to), 32'd0);

    // Directed frames
    do_frame(8'h05, 8'h03, 8'h20, 1'b0);
    do_frame(8'h03, 8'h05, 8'h22, 1'b0);
    do_frame(8'hF0, 8'h0F, 8'h27, 1'b0);
    do_frame(8'h05, 8'h03, 8'h21, 1'b0);
    do_frame(8'h01, 8'h01, 8'h20, 1'b0);

    // Gap timeout after operand A
    send_byte(8'h05);
    m_a = 8'h05;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("no_early_timeout", 32'(err_to), 32'd0);
    end
    @(negedge clk);
    check("err_timeout", 32'(err_to), 32'd1);
    check("timeout_keep_a", 32'(alu_a), 32'(m_a));
    check("timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("timeout_single", 32'(err_to), 32'd0);
    do_frame(8'h07, 8'h01, 8'h24, 1'b0);

    // Operand B arrives on the expiry cycle
    s = n_eto;
    send_byte(8'h09);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h04);
    m_a = 8'h09;
    m_b = 8'h04;
    repeat (3) begin
      @(negedge clk);
      check("expiry_byte_no_to", 32'(err_to), 32'd0);
    end
    send_byte(8'h20);
    m_op = 6'h20;
    expect_result(8'h0D, 1'b0);
    check("expiry_no_to_count", 32'(n_eto), 32'(s));

    // Received byte during WAIT_TX is dropped
    do_frame(8'h10, 8'h20, 8'h25, 1'b1);
    do_frame(8'h02, 8'h01, 8'h02, 1'b0);

    // Tx_Done coincident with Tx_Start is ignored
    send_frame(8'h06, 8'h02, 8'h26);
    m_op = 6'h26;
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(negedge clk);
    check("coinc_start", 32'(tx_start), 32'd1);
    check("coinc_data", 32'(tx_data), 32'h04);
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("coinc_hold_busy", 32'(busy), 32'd1);
    pulse_tx();
    @(negedge clk);
    check("coinc_busy_fall", 32'(busy), 32'd0);

    // Reset while waiting for the opcode
    send_byte(8'h11);
    send_byte(8'h22);
    s = n_txs;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(alu_b), 32'd0);
    check("mid_rst_alu_op", 32'(alu_op), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_errs", 32'({err_op, err_to, tx_start}), 32'd0);
    m_a = '0; m_b = '0; m_op = '0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_start", 32'(n_txs), 32'(s));
    do_frame(8'h0A, 8'h03, 8'h22, 1'b0);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb, rop;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) rop = 8'($urandom);
      else                           rop = valid_ops[$urandom_range(0, 7)];
      do_frame(ra, rb, rop, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
